// File: rtl/oc8051_ifetch_pkg.sv
// rtl/oc8051_ifetch_pkg.sv - shared types and constants for the oc8051 instruction-fetch buffer
//
// Purpose: byte/PC types and fetch geometry used by the fetch buffer and its byte queue.
// Optional feature macro used by the bundle: OC8051_IFETCH_STATS_EN.
package oc8051_ifetch_pkg;

  localparam int FETCH_BYTES    = 4;  // bytes returned per code-ROM access
  localparam int MAX_INSN_BYTES = 3;  // longest 8051 instruction, size of the decode window

  typedef logic [7:0]  byte_t;
  typedef logic [15:0] pc_t;

endpackage

// File: rtl/oc8051_ifetch_buf_if.sv
// rtl/oc8051_ifetch_buf_if.sv - code-ROM port and decoder window bundle for oc8051_ifetch_buf
//
// Purpose: groups the ROM fetch port and the decoder-facing window/redirect signals.
// Modports:
//   master - the fetch buffer: drives cxrom_addr and the opcode window, receives ROM data,
//            redirects and consume requests.
//   slave  - the surrounding core/ROM: the mirror image.
// Optional feature macro used by the bundle: OC8051_IFETCH_STATS_EN.
interface oc8051_ifetch_buf_if;
  import oc8051_ifetch_pkg::*;

  pc_t         cxrom_addr;
  logic [31:0] cxrom_data_in;
  logic        redirect_valid;
  pc_t         redirect_pc;
  logic [1:0]  consume_len;
  byte_t       op_byte0;
  byte_t       op_byte1;
  byte_t       op_byte2;
  logic [1:0]  op_count;
  pc_t         op_pc;

  modport master (
    output cxrom_addr, op_byte0, op_byte1, op_byte2, op_count, op_pc,
    input  cxrom_data_in, redirect_valid, redirect_pc, consume_len
  );

  modport slave (
    input  cxrom_addr, op_byte0, op_byte1, op_byte2, op_count, op_pc,
    output cxrom_data_in, redirect_valid, redirect_pc, consume_len
  );

endinterface

// File: rtl/oc8051_ifetch_queue.sv
// rtl/oc8051_ifetch_queue.sv - circular byte FIFO with 4-wide push, 0-3 byte pop and 3-byte peek
//
// Purpose: prefetch storage for the fetch buffer.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   flush             empty the queue and zero both pointers (wins over push/pop)
//   push, push_data   write FETCH_BYTES bytes, push_data[7:0] first
//   pop_len           bytes to retire; caller guarantees pop_len <= count
//   peek0..peek2      first three bytes, zero beyond count
//   count             min(occ, 3)
//   occ               current occupancy, 0..DEPTH
// Optional feature macro used by the bundle: OC8051_IFETCH_STATS_EN (not used here).
module oc8051_ifetch_queue
  import oc8051_ifetch_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [FETCH_BYTES*8-1:0]   push_data,
  input  logic [1:0]                 pop_len,
  output byte_t                      peek0,
  output byte_t                      peek1,
  output byte_t                      peek2,
  output logic [1:0]                 count,
  output logic [$clog2(DEPTH):0]     occ
);

  localparam int PW = $clog2(DEPTH);

  byte_t         mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   occ_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ_q  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ_q  <= '0;
    end else begin
      rd_ptr <= rd_ptr + PW'(pop_len);
      if (push) wr_ptr <= wr_ptr + PW'(FETCH_BYTES);
      occ_q <= occ_q - (PW+1)'(pop_len) + (push ? (PW+1)'(FETCH_BYTES) : '0);
    end
  end

  // Storage needs no reset: bytes outside the valid window are masked on read.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      for (int i = 0; i < FETCH_BYTES; i++) begin
        mem[wr_ptr + PW'(i)] <= push_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    count = (occ_q >= (PW+1)'(MAX_INSN_BYTES)) ? 2'd3 : occ_q[1:0];
    peek0 = (count > 2'd0) ? mem[rd_ptr]          : 8'h00;
    peek1 = (count > 2'd1) ? mem[rd_ptr + PW'(1)] : 8'h00;
    peek2 = (count > 2'd2) ? mem[rd_ptr + PW'(2)] : 8'h00;
  end

  assign occ = occ_q;

endmodule

// File: rtl/oc8051_ifetch_buf.sv
// rtl/oc8051_ifetch_buf.sv - oc8051 instruction-fetch requester with byte prefetch queue
//
// Purpose: drives the combinational 32-bit code-ROM port, buffers returned bytes and presents
//          a 3-byte opcode window with its PC; handles 1-3 byte consumption and redirects.
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   bus (master)              cxrom_addr/cxrom_data_in ROM port, redirect_valid/redirect_pc,
//                             consume_len, op_byte0..2/op_count/op_pc window
//   stat_clr, stat_fetches,   only with OC8051_IFETCH_STATS_EN: saturating fetch and
//   stat_redirects            redirect counters with synchronous clear
module oc8051_ifetch_buf
  import oc8051_ifetch_pkg::*;
#(
  parameter int  DEPTH    = 8,
  parameter pc_t RESET_PC = 16'h0000
) (
  input  logic                clk,
  input  logic                rst,
  oc8051_ifetch_buf_if.master bus
`ifdef OC8051_IFETCH_STATS_EN
  ,
  input  logic                stat_clr,
  output logic [31:0]         stat_fetches,
  output logic [31:0]         stat_redirects
`endif
);

  localparam int OW = $clog2(DEPTH) + 1;

  pc_t        fetch_pc;
  pc_t        op_pc;
  logic [OW-1:0] occ;
  logic [1:0] count;
  logic [1:0] eff;
  logic       fetch_fire;

  // Fetch decision uses occupancy before this cycle's consume, so a full-width
  // write always fits even if nothing is retired.
  assign fetch_fire = !bus.redirect_valid && (occ <= OW'(DEPTH - FETCH_BYTES));
  assign eff        = bus.redirect_valid ? 2'd0
                    : ((bus.consume_len < count) ? bus.consume_len : count);

  oc8051_ifetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect_valid),
    .push      (fetch_fire),
    .push_data (bus.cxrom_data_in),
    .pop_len   (eff),
    .peek0     (bus.op_byte0),
    .peek1     (bus.op_byte1),
    .peek2     (bus.op_byte2),
    .count     (count),
    .occ       (occ)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      op_pc    <= RESET_PC;
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_pc;
      op_pc    <= bus.redirect_pc;
    end else begin
      if (fetch_fire) fetch_pc <= fetch_pc + pc_t'(FETCH_BYTES);
      op_pc <= op_pc + pc_t'(eff);
    end
  end

  assign bus.cxrom_addr = fetch_pc;
  assign bus.op_count   = count;
  assign bus.op_pc      = op_pc;

`ifdef OC8051_IFETCH_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_fetches   <= '0;
      stat_redirects <= '0;
    end else if (stat_clr) begin
      stat_fetches   <= '0;
      stat_redirects <= '0;
    end else begin
      if (fetch_fire && (stat_fetches != 32'hFFFF_FFFF))
        stat_fetches <= stat_fetches + 32'd1;
      if (bus.redirect_valid && (stat_redirects != 32'hFFFF_FFFF))
        stat_redirects <= stat_redirects + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_oc8051_ifetch_buf.sv
// tb/tb_oc8051_ifetch_buf.sv - self-checking bench for oc8051_ifetch_buf against a byte-queue model
module tb_oc8051_ifetch_buf;
  import oc8051_ifetch_pkg::*;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  oc8051_ifetch_buf_if bus ();

`ifdef OC8051_IFETCH_STATS_EN
  logic        stat_clr = 1'b0;
  logic [31:0] stat_fetches;
  logic [31:0] stat_redirects;
`endif

  oc8051_ifetch_buf #(.DEPTH(DEPTH), .RESET_PC(16'h0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
`ifdef OC8051_IFETCH_STATS_EN
    ,
    .stat_clr       (stat_clr),
    .stat_fetches   (stat_fetches),
    .stat_redirects (stat_redirects)
`endif
  );

  // Combinational code ROM.
  byte_t rom [65536];
  pc_t a1, a2, a3;
  assign a1 = bus.cxrom_addr + 16'd1;
  assign a2 = bus.cxrom_addr + 16'd2;
  assign a3 = bus.cxrom_addr + 16'd3;
  assign bus.cxrom_data_in = {rom[a3], rom[a2], rom[a1], rom[bus.cxrom_addr]};

  // Reference model: the prefetch queue is literally a queue of bytes.
  byte_t m_q[$];
  pc_t   m_fetch_pc;
  pc_t   m_op_pc;
  longint m_fetches;
  longint m_redirects;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_fetch_pc  = 16'h0000;
    m_op_pc     = 16'h0000;
    m_fetches   = 0;
    m_redirects = 0;
  endtask

  task automatic model_cycle(input logic rv, input pc_t rpc, input int cl, input logic clr);
    int avail;
    int eff;
    bit fire;
    if (rv) begin
      m_q.delete();
      m_fetch_pc = rpc;
      m_op_pc    = rpc;
      fire       = 0;
    end else begin
      avail = (m_q.size() > 3) ? 3 : m_q.size();
      eff   = (cl < avail) ? cl : avail;
      fire  = (m_q.size() <= DEPTH - 4);
      repeat (eff) void'(m_q.pop_front());
      m_op_pc = m_op_pc + pc_t'(eff);
      if (fire) begin
        for (int k = 0; k < 4; k++) m_q.push_back(rom[m_fetch_pc + pc_t'(k)]);
        m_fetch_pc = m_fetch_pc + 16'd4;
      end
    end
    if (clr) begin
      m_fetches   = 0;
      m_redirects = 0;
    end else begin
      if (fire && m_fetches < 64'hFFFF_FFFF) m_fetches++;
      if (rv && m_redirects < 64'hFFFF_FFFF) m_redirects++;
    end
  endtask

  task automatic compare_all();
    int n;
    n = (m_q.size() > 3) ? 3 : m_q.size();
    chk("cxrom_addr", bus.cxrom_addr, m_fetch_pc);
    chk("op_count", bus.op_count, n);
    chk("op_pc", bus.op_pc, m_op_pc);
    chk("op_byte0", bus.op_byte0, (n > 0) ? m_q[0] : 8'h00);
    chk("op_byte1", bus.op_byte1, (n > 1) ? m_q[1] : 8'h00);
    chk("op_byte2", bus.op_byte2, (n > 2) ? m_q[2] : 8'h00);
    chk("occ_bound", (m_q.size() <= DEPTH), 1);
`ifdef OC8051_IFETCH_STATS_EN
    chk("stat_fetches", stat_fetches, m_fetches[31:0]);
    chk("stat_redirects", stat_redirects, m_redirects[31:0]);
`endif
  endtask

  task automatic step(input logic rv, input pc_t rpc, input logic [1:0] cl, input logic clr = 1'b0);
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.consume_len    = cl;
`ifdef OC8051_IFETCH_STATS_EN
    stat_clr = clr;
`endif
    @(posedge clk);
    #1;
    model_cycle(rv, rpc, int'(cl), clr);
    compare_all();
  endtask

  initial begin
    pc_t rpc;
    for (int i = 0; i < 65536; i++) rom[i] = byte_t'($urandom);
    rom[16'h0000] = 8'h02; rom[16'h0001] = 8'h00; rom[16'h0002] = 8'h06;
    rom[16'h0003] = 8'h02; rom[16'h0004] = 8'h00; rom[16'h0005] = 8'h88;
    rom[16'h0088] = 8'h7E; rom[16'h0089] = 8'h01; rom[16'h008A] = 8'h7F;
    rom[16'hFFFE] = 8'hA5; rom[16'hFFFF] = 8'h5A;

    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 16'h0000;
    bus.consume_len    = 2'd0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 1'b0;

    // First fetch lands at the end of cycle 1.
    step(1'b0, 16'h0000, 2'd0);
    chk("boot_count", bus.op_count, 3);
    chk("boot_win", {bus.op_byte0, bus.op_byte1, bus.op_byte2}, 24'h020006);
    repeat (4) step(1'b0, 16'h0000, 2'd0);
    chk("stall_addr", bus.cxrom_addr, 16'h0008);

    // occ 8 -> 6, then redirect with a consume request that must be ignored.
    step(1'b0, 16'h0000, 2'd2);
    step(1'b1, 16'h0088, 2'd2);
    chk("redir_addr", bus.cxrom_addr, 16'h0088);
    chk("redir_empty", bus.op_count, 0);
    step(1'b0, 16'h0000, 2'd3);
    chk("redir_win", {bus.op_byte0, bus.op_byte1, bus.op_byte2}, 24'h7E017F);
    chk("redir_pc", bus.op_pc, 16'h0088);

    // Sustained 3-byte consumption from a full queue.
    repeat (3) step(1'b0, 16'h0000, 2'd0);
    repeat (12) step(1'b0, 16'h0000, 2'd3);

    // Fetch across the 64K wrap.
    step(1'b1, 16'hFFFE, 2'd0);
    step(1'b0, 16'h0000, 2'd0);
    chk("wrap_win", {bus.op_byte0, bus.op_byte1, bus.op_byte2}, 24'hA55A02);
    step(1'b0, 16'h0000, 2'd2);
    chk("wrap_pc", bus.op_pc, 16'h0000);
    chk("wrap_b0", bus.op_byte0, 8'h02);
    chk("wrap_b2", bus.op_byte2, 8'h06);

`ifdef OC8051_IFETCH_STATS_EN
    step(1'b0, 16'h0000, 2'd1, 1'b1);
    chk("stat_clr_f", stat_fetches, 0);
`endif

    // Randomized traffic, with occasional redirects near the top of memory.
    for (int i = 0; i < 600; i++) begin
      rpc = ($urandom_range(0, 3) == 0) ? (16'hFFFC + pc_t'($urandom_range(0, 3)))
                                        : pc_t'($urandom);
      step(($urandom_range(0, 15) == 0), rpc, 2'($urandom_range(0, 3)));
      if (i == 300) begin
        rst = 1'b1;
        #1;
        model_reset();
        compare_all();
        rst = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/oc8051_ifetch_buf.md
Name: oc8051_ifetch_buf

Overview:
Instruction-fetch requester for the oc8051 core; the initiator side of the 32-bit combinational code-ROM port.
- Drives a 16-bit fetch address each cycle and captures the 4 returned bytes into a byte-wide circular prefetch queue.
- Presents a 3-byte opcode window, plus its PC, to the decoder.
- Handles variable-length consumption (1-3 bytes) and branch redirects that flush the queue.

Parameters:
DEPTH, 8, queue capacity in bytes; power of two, >= 8.
RESET_PC, 16'h0000, fetch and window PC after reset.

Ports:
clk  in  1  core clock, rising edge.
rst  in  1  asynchronous, active-high reset.
cxrom_addr  out  16  ROM fetch address; equals fetch_pc register.
cxrom_data_in  in  32  ROM data, same cycle; [7:0]=byte at addr, [15:8]=addr+1, [23:16]=addr+2, [31:24]=addr+3.
redirect_valid  in  1  flush queue and restart fetching at redirect_pc.
redirect_pc  in  16  branch/jump target.
consume_len  in  2  bytes retired from window this cycle; 0 = none.
op_byte0  out  8  window byte at op_pc.
op_byte1  out  8  byte at op_pc+1.
op_byte2  out  8  byte at op_pc+2.
op_count  out  2  valid window bytes, min(occupancy,3).
op_pc  out  16  address of op_byte0.

Behaviour:
- Clock and reset: one clock; asynchronous active-high reset on rst.
- State: fetch_pc, op_pc, rd_ptr, wr_ptr, occ (0..DEPTH). All registered; no FSM beyond the queue.
- Reset values:
  - fetch_pc = op_pc = RESET_PC; cxrom_addr = RESET_PC.
  - occ = 0, so op_count = 0.
  - op_byte0..2 = 8'h00. Window bytes are forced to 0 when beyond op_count.
- Fetch rule: fetch_fire = !redirect_valid && (occ <= DEPTH-4), using pre-consume occ.
  - On fire: write the 4 bytes at wr_ptr..wr_ptr+3, wr_ptr += 4, fetch_pc += 4 (mod 2^16).
  - ROM is combinational, so capture happens at the end of the same cycle the address is driven.
- Consume: eff = min(consume_len, op_count); an over-request is clamped, never underflows.
  - rd_ptr += eff; op_pc += eff (mod 2^16).
- Occupancy: occ_next = occ - eff + (fetch_fire ? 4 : 0). Simultaneous consume and fetch are legal.
- Redirect has priority over both consume and fetch. Next cycle:
  - occ = 0, rd_ptr = wr_ptr = 0.
  - fetch_pc = op_pc = redirect_pc.
  - The cxrom_data_in of the redirect cycle is discarded.
- Redirect latency: redirect at cycle N gives cxrom_addr = target at N+1 and op_count = 3 at N+2.
- Steady-state bandwidth: 4 bytes/cycle fetched vs <= 3 consumed. The queue saturates and fetch stalls whenever occ > DEPTH-4.
- Wrap-around:
  - Queue pointers wrap mod DEPTH.
  - fetch_pc and op_pc wrap 16'hFFFF -> 16'h0000; bytes fetched across the wrap are contiguous.
- Window read is combinational from rd_ptr and occ.
- Reset asserted mid-operation: immediately returns all state to reset values; in-flight data is dropped.

Optional Feature:
OC8051_IFETCH_STATS_EN
- Defined: adds outputs stat_fetches (32) and stat_redirects (32), plus input stat_clr.
  - Counters increment on fetch_fire and on redirect_valid respectively.
  - Both saturate at 32'hFFFFFFFF.
  - Both are cleared by rst (async) or stat_clr (sync); stat_clr wins over increment.
- Undefined: the ports and counters are absent; core behaviour is identical.

Decomposition:
- Package oc8051_ifetch_pkg:
  - FETCH_BYTES = 4, MAX_INSN_BYTES = 3.
  - byte_t (8-bit), pc_t (16-bit).
- Sub-module oc8051_ifetch_queue: circular byte FIFO with a 4-wide push, 0-3 byte pop, 3-byte peek window and occ output.
- The top level owns fetch_pc, op_pc, the redirect logic and the stats.

Test Plan:
- Reset then idle, ROM bytes 02 00 06 02 00 88 ... at 0x0000:
  - cycle 1: cxrom_addr = 0x0000.
  - cycle 2: op_count = 3, window = 02 00 06, op_pc = 0x0000.
  - fetch stalls with occ = 8 after 2 fetches.
- consume_len = 3 every cycle from a full queue: op_pc advances 0,3,6,9...; window bytes match ROM; occ never > DEPTH; no byte skipped or duplicated.
- Redirect to 0x0088 while occ = 6 and consume_len = 2:
  - consume ignored.
  - cxrom_addr = 0x0088 next cycle.
  - window 7E 01 7F two cycles after the redirect, op_pc = 0x0088.
- Redirect to 0xFFFE: fetched bytes at FFFE, FFFF, 0000, 0001 appear in order; op_pc wraps to 0x0000 after consuming 2.
- consume_len = 3 with op_count = 1 (first cycle after a redirect is impossible, so force via a stalled ROM model): only 1 byte retired, op_pc += 1, no underflow.
- With OC8051_IFETCH_STATS_EN:
  - 10 fetches and 2 redirects give stat_fetches = 10, stat_redirects = 2.
  - stat_clr zeroes both next cycle.
  - a counter preloaded at max stays saturated.
